mag_comp_arbiter: RTL and testbench

MAG_COMP_ARBITER -- requirements
Module: mag_comp_arbiter

---
 rtl/mag_comp_arbiter_pkg.sv | 21 ++
 rtl/mag_comp_arbiter_if.sv | 35 +++
 rtl/mag_comp4.sv | 21 ++
 rtl/mag_comp_arbiter.sv | 116 +++++++++++
 tb/tb_mag_comp_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mag_comp_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// mag_comp_arbiter_pkg : shared width default and FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------
package mag_comp_arbiter_pkg;

    localparam int WIDTH_DEFAULT = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EVAL = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_EVAL = ST_EVAL,
        S_RESP = ST_RESP
    } state_e;

endpackage
`default_nettype wire

// File: rtl/mag_comp_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// mag_comp_arbiter_if : request/operand/result bundle for both ports
// Rev 1.0
// ---------------------------------------------------------------------
interface mag_comp_arbiter_if #(
    parameter int WIDTH = mag_comp_arbiter_pkg::WIDTH_DEFAULT
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             busy0;
    logic             busy1;
    logic             drop0;
    logic             drop1;
    logic             done0;
    logic             done1;
    logic             aeqb;
    logic             agtb;
    logic             altb;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  busy0, busy1, drop0, drop1, done0, done1, aeqb, agtb, altb
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output busy0, busy1, drop0, drop1, done0, done1, aeqb, agtb, altb
    );
endinterface
`default_nettype wire

// File: rtl/mag_comp4.sv
`default_nettype none
// ---------------------------------------------------------------------
// mag_comp4 : combinational unsigned magnitude comparator
// Rev 1.0
// ---------------------------------------------------------------------
module mag_comp4
    import mag_comp_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic [WIDTH-1:0] a,
    input  wire logic [WIDTH-1:0] b,
    output logic                  aeqb,
    output logic                  agtb,
    output logic                  altb
);
    assign aeqb = (a == b);
    assign agtb = (a > b);
    assign altb = (a < b);
endmodule
`default_nettype wire

// File: rtl/mag_comp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------
// mag_comp_arbiter : two requesters share one comparator, round-robin
// Rev 1.0
// ---------------------------------------------------------------------
module mag_comp_arbiter
    import mag_comp_arbiter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    mag_comp_arbiter_if.slave  bus
);
    state_e           r_state;
    logic             r_pend0, r_pend1;
    logic [WIDTH-1:0] r_a0, r_b0, r_a1, r_b1;
    logic [WIDTH-1:0] r_cmp_a, r_cmp_b;
    logic             r_grant;
    logic             r_drop0, r_drop1, r_done0, r_done1;
    logic             r_aeqb, r_agtb, r_altb;

    logic w_busy0, w_busy1, w_pick1, w_take0, w_take1;
    logic w_eq, w_gt, w_lt;

    assign w_busy0 = r_pend0 | ((r_state != S_IDLE) & ~r_grant);
    assign w_busy1 = r_pend1 | ((r_state != S_IDLE) &  r_grant);

    // r_grant doubles as last-grant; on a tie the port not served last wins
    assign w_pick1 = r_pend1 & (~r_pend0 | ~r_grant);
    assign w_take0 = (r_state == S_IDLE) & r_pend0 & ~w_pick1;
    assign w_take1 = (r_state == S_IDLE) & w_pick1;

    mag_comp4 #(.WIDTH(WIDTH)) u_cmp (
        .a    (r_cmp_a),
        .b    (r_cmp_b),
        .aeqb (w_eq),
        .agtb (w_gt),
        .altb (w_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
            r_a0    <= '0;
            r_b0    <= '0;
            r_a1    <= '0;
            r_b1    <= '0;
            r_cmp_a <= '0;
            r_cmp_b <= '0;
            r_grant <= 1'b1;
            r_drop0 <= 1'b0;
            r_drop1 <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_aeqb  <= 1'b0;
            r_agtb  <= 1'b0;
            r_altb  <= 1'b0;
        end else begin
            r_drop0 <= bus.req0 & w_busy0;
            r_drop1 <= bus.req1 & w_busy1;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;

            if (bus.req0 && !w_busy0) begin
                r_pend0 <= 1'b1;
                r_a0    <= bus.a0;
                r_b0    <= bus.b0;
            end else if (w_take0) begin
                r_pend0 <= 1'b0;
            end

            if (bus.req1 && !w_busy1) begin
                r_pend1 <= 1'b1;
                r_a1    <= bus.a1;
                r_b1    <= bus.b1;
            end else if (w_take1) begin
                r_pend1 <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (r_pend0 || r_pend1) begin
                        r_state <= S_EVAL;
                        r_grant <= w_pick1;
                        r_cmp_a <= w_pick1 ? r_a1 : r_a0;
                        r_cmp_b <= w_pick1 ? r_b1 : r_b0;
                    end
                end
                S_EVAL: begin
                    r_aeqb  <= w_eq;
                    r_agtb  <= w_gt;
                    r_altb  <= w_lt;
                    r_done0 <= ~r_grant;
                    r_done1 <= r_grant;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy0 = w_busy0;
    assign bus.busy1 = w_busy1;
    assign bus.drop0 = r_drop0;
    assign bus.drop1 = r_drop1;
    assign bus.done0 = r_done0;
    assign bus.done1 = r_done1;
    assign bus.aeqb  = r_aeqb;
    assign bus.agtb  = r_agtb;
    assign bus.altb  = r_altb;
endmodule
`default_nettype wire

// File: tb/tb_mag_comp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_mag_comp_arbiter : directed self-checking bench for mag_comp_arbiter
// Rev 1.0
// ---------------------------------------------------------------------
module tb_mag_comp_arbiter;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mag_comp_arbiter_if #(.WIDTH(4)) bus ();

    mag_comp_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // one isolated port-0 service; result checked in its done cycle
    task automatic svc0(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic eq, input logic gt, input logic lt);
        bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        step();
        step();
        chk({tag, "_done0"}, bus.done0, 1'b1);
        chk({tag, "_res"}, {bus.aeqb, bus.agtb, bus.altb}, {eq, gt, lt});
        step();
    endtask

    int   n_svc;
    int   cnt;
    logic order [6];

    initial begin
        clk = 1'b0; rst_n = 1'b0;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        bus.a0 = 4'd0; bus.b0 = 4'd0; bus.a1 = 4'd0; bus.b1 = 4'd0;
        checks = 0; errors = 0;

        // reset state, with requests held high to show they are ignored
        step();
        step();
        chk("rst_outs", {bus.busy0, bus.busy1, bus.drop0, bus.drop1, bus.done0,
                         bus.done1, bus.aeqb, bus.agtb, bus.altb}, 9'd0);
        bus.req0 = 1'b0; bus.req1 = 1'b0; rst_n = 1'b1;
        step();
        chk("rst_no_pend", {bus.busy0, bus.busy1}, 2'b00);

        // single request, latency 3
        bus.a0 = 4'd5; bus.b0 = 4'd3; bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        chk("t1_busy0", bus.busy0, 1'b1);
        step();
        step();
        chk("t1_done0", bus.done0, 1'b1);
        chk("t1_done1", bus.done1, 1'b0);
        chk("t1_res", {bus.aeqb, bus.agtb, bus.altb}, 3'b010);
        step();
        chk("t1_after", {bus.done0, bus.busy0, bus.agtb}, 3'b001);

        // simultaneous requests after reset: port 0 first
        do_reset();
        bus.a0 = 4'd2; bus.b0 = 4'd9; bus.a1 = 4'd7; bus.b1 = 4'd7;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        step();
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        step();
        step();
        chk("t2_first", {bus.done0, bus.done1}, 2'b10);
        chk("t2_res0", {bus.aeqb, bus.agtb, bus.altb}, 3'b001);
        step();
        step();
        step();
        chk("t2_second", {bus.done0, bus.done1}, 2'b01);
        chk("t2_res1", {bus.aeqb, bus.agtb, bus.altb}, 3'b100);
        step();

        // request while busy is dropped
        bus.a0 = 4'd1; bus.b0 = 4'd1; bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        step();
        bus.a0 = 4'd9; bus.b0 = 4'd1; bus.req0 = 1'b1;
        step();
        bus.req0 = 1'b0;
        chk("t3_drop0", bus.drop0, 1'b1);
        chk("t3_done0", bus.done0, 1'b1);
        chk("t3_res", {bus.aeqb, bus.agtb, bus.altb}, 3'b100);
        step();
        chk("t3_after", {bus.busy0, bus.drop0, bus.done0}, 3'b000);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (bus.done0) cnt++;
        end
        chk("t3_no_extra_done", cnt, 0);

        // operand boundaries
        svc0("b_15_0", 4'd15, 4'd0, 1'b0, 1'b1, 1'b0);
        svc0("b_0_15", 4'd0, 4'd15, 1'b0, 1'b0, 1'b1);
        svc0("b_15_15", 4'd15, 4'd15, 1'b1, 1'b0, 1'b0);
        svc0("b_0_0", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);

        // continuous requests on both ports alternate grants
        do_reset();
        bus.a0 = 4'd1; bus.b0 = 4'd2; bus.a1 = 4'd3; bus.b1 = 4'd3;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n_svc = 0;
        for (int i = 0; i < 60 && n_svc < 6; i++) begin
            step();
            if (bus.done0 && bus.done1) begin
                chk("rr_both_done", 1'b1, 1'b0);
            end else if (bus.done0 || bus.done1) begin
                order[n_svc] = bus.done1;
                n_svc++;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr_count", n_svc, 6);
        for (int i = 0; i < 6; i++) begin
            if (i < n_svc) chk($sformatf("rr_grant%0d", i), order[i], (i % 2 == 1));
        end

        // reset during EVAL aborts port-1 service
        do_reset();
        bus.a1 = 4'd4; bus.b1 = 4'd6; bus.req1 = 1'b1;
        step();
        bus.req1 = 1'b0;
        step();
        rst_n = 1'b0; bus.req0 = 1'b1;
        step();
        chk("abort_outs", {bus.done1, bus.busy0, bus.busy1, bus.aeqb, bus.agtb, bus.altb}, 6'd0);
        rst_n = 1'b1; bus.req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.done0 || bus.done1 || bus.busy0 || bus.busy1) cnt++;
        end
        chk("abort_quiet", cnt, 0);
        bus.a1 = 4'd8; bus.b1 = 4'd2; bus.req1 = 1'b1;
        step();
        bus.req1 = 1'b0;
        step();
        step();
        chk("abort_next_done1", {bus.done0, bus.done1}, 2'b01);
        chk("abort_next_res", {bus.aeqb, bus.agtb, bus.altb}, 3'b010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
